// File: rtl/block_sync_rx.sv
// 64b/66b receive block-lock controller: hunts for sync-header alignment by
// slipping the RX gearbox, then holds lock until too many headers go bad.
module block_sync_rx #(
    parameter int HEAD_W     = 2,
    parameter int SH_CNT_MAX = 64,
    parameter int SH_INV_MAX = 16,
    parameter int SLIP_WAIT  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              signal_ok_i,
    input  logic              valid_i,
    input  logic [HEAD_W-1:0] head_i,
    output logic              slip_v_o,
    output logic              lock_v_o
);

    localparam int CNT_W  = $clog2(SH_CNT_MAX + 1);
    localparam int WAIT_W = $clog2(SLIP_WAIT + 1);

    localparam logic [1:0] ST_UNLOCK = 2'd0;
    localparam logic [1:0] ST_SLIP   = 2'd1;
    localparam logic [1:0] ST_LOCK   = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  sh_cnt_q, sh_cnt_d;
    logic [CNT_W-1:0]  inv_cnt_q, inv_cnt_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              slip_q, slip_d;
    logic              lock_q;

    logic              sh_ok;
    logic [CNT_W-1:0]  sh_cnt_inc;
    logic [CNT_W-1:0]  inv_cnt_inc;

    // Only the two transition patterns 01/10 mark a legal 66b sync header.
    assign sh_ok       = (head_i == HEAD_W'(1)) || (head_i == HEAD_W'(2));
    assign sh_cnt_inc  = sh_cnt_q + CNT_W'(1);
    assign inv_cnt_inc = inv_cnt_q + (sh_ok ? CNT_W'(0) : CNT_W'(1));

    always_comb begin
        // NOTE: every next-state signal gets a hold default first, so no path leaves it unassigned and no latch is inferred.
        state_d    = state_q;
        sh_cnt_d   = sh_cnt_q;
        inv_cnt_d  = inv_cnt_q;
        wait_cnt_d = wait_cnt_q;
        slip_d     = 1'b0;

        if (!signal_ok_i) begin
            state_d    = ST_UNLOCK;
            sh_cnt_d   = '0;
            inv_cnt_d  = '0;
            wait_cnt_d = '0;
        end else if (valid_i) begin
            case (state_q)
                ST_UNLOCK: begin
                    if (!sh_ok) begin
                        state_d  = ST_SLIP;
                        slip_d   = 1'b1;
                        sh_cnt_d = '0;
                    end else if (sh_cnt_inc == CNT_W'(SH_CNT_MAX)) begin
                        state_d  = ST_LOCK;
                        sh_cnt_d = '0;
                    end else begin
                        sh_cnt_d = sh_cnt_inc;
                    end
                end
                ST_SLIP: begin
                    // Headers here still reflect the pre-slip alignment, so they are only counted off.
                    if (wait_cnt_q == WAIT_W'(SLIP_WAIT - 1)) begin
                        state_d    = ST_UNLOCK;
                        wait_cnt_d = '0;
                        sh_cnt_d   = '0;
                        inv_cnt_d  = '0;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    end
                end
                ST_LOCK: begin
                    // Invalid limit is tested first so a coincident window end still slips.
                    if (inv_cnt_inc == CNT_W'(SH_INV_MAX)) begin
                        state_d   = ST_SLIP;
                        slip_d    = 1'b1;
                        sh_cnt_d  = '0;
                        inv_cnt_d = '0;
                    end else if (sh_cnt_inc == CNT_W'(SH_CNT_MAX)) begin
                        sh_cnt_d  = '0;
                        inv_cnt_d = '0;
                    end else begin
                        sh_cnt_d  = sh_cnt_inc;
                        inv_cnt_d = inv_cnt_inc;
                    end
                end
                default: begin
                    state_d    = ST_UNLOCK;
                    sh_cnt_d   = '0;
                    inv_cnt_d  = '0;
                    wait_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q    <= ST_UNLOCK;
            sh_cnt_q   <= '0;
            inv_cnt_q  <= '0;
            wait_cnt_q <= '0;
            slip_q     <= 1'b0;
            lock_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sh_cnt_q   <= sh_cnt_d;
            inv_cnt_q  <= inv_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            slip_q     <= slip_d;
            lock_q     <= (state_d == ST_LOCK);
        end
    end

    assign slip_v_o = slip_q;
    assign lock_v_o = lock_q;

endmodule

// File: tb/tb_block_sync_rx.sv
// Directed bench for block_sync_rx: the driver queues the hand-derived output
// expected after each edge, a monitor pops and compares just after that edge.
module tb_block_sync_rx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       signal_ok_i = 1'b1;
    logic       valid_i = 1'b0;
    logic [1:0] head_i = 2'b01;
    logic       slip_v_o;
    logic       lock_v_o;

    typedef struct {
        logic  slip;
        logic  lock;
        string name;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    block_sync_rx dut (
        .clk        (clk),
        .reset      (reset),
        .signal_ok_i(signal_ok_i),
        .valid_i    (valid_i),
        .head_i     (head_i),
        .slip_v_o   (slip_v_o),
        .lock_v_o   (lock_v_o)
    );

    always #5 clk = ~clk;

    // Monitor: outputs settle just after the edge that consumed the queued inputs.
    always @(posedge clk) begin
        #1;
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            n_vec++;
            if (slip_v_o !== e.slip || lock_v_o !== e.lock) begin
                n_fail++;
                $display("FAIL %s @%0t: slip=%0b lock=%0b, expected slip=%0b lock=%0b",
                         e.name, $time, slip_v_o, lock_v_o, e.slip, e.lock);
            end
        end
    end

    // One cycle of stimulus plus the outputs expected after its clock edge.
    task automatic blk(input logic ok, input logic v, input logic [1:0] h, input logic rst,
                       input logic es, input logic el, input string nm);
        @(negedge clk);
        reset       = rst;
        signal_ok_i = ok;
        valid_i     = v;
        head_i      = h;
        sb.push_back('{slip: es, lock: el, name: nm});
    endtask

    task automatic do_reset();
        blk(1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, "reset");
    endtask

    // Clean start then 64 good headers: lock appears only after the 64th.
    task automatic acquire(input string nm);
        do_reset();
        for (int k = 0; k < 64; k++)
            blk(1'b1, 1'b1, (k % 2) ? 2'b10 : 2'b01, 1'b0, 1'b0, k == 63, nm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state, including two reset cycles back to back.
        do_reset();
        do_reset();

        // Aligned stream.
        do_reset();
        for (int k = 0; k < 64; k++)
            blk(1'b1, 1'b1, 2'b01, 1'b0, 1'b0, k == 63, "aligned");
        blk(1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 1'b1, "aligned_hold");

        // Signal loss while locked: lock drops, no slip; restart counts from zero.
        blk(1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, "sigloss_lock");
        blk(1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, "sigloss_bad_hdr");
        for (int k = 0; k < 64; k++)
            blk(1'b1, 1'b1, 2'b01, 1'b0, 1'b0, k == 63, "sigloss_relock");

        // Misaligned start: one slip, two ignored valid blocks, skip cycles not counted.
        do_reset();
        blk(1'b1, 1'b1, 2'b11, 1'b0, 1'b1, 1'b0, "misalign_slip");
        blk(1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, "misalign_wait1");
        blk(1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, "misalign_gap");
        blk(1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, "misalign_wait2");
        blk(1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, "misalign_reslip");
        blk(1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, "settle_ignored1");
        blk(1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, "settle_ignored2");
        for (int k = 0; k < 64; k++)
            blk(1'b1, 1'b1, 2'b10, 1'b0, 1'b0, k == 63, "settle_lock");

        // Error tolerance: 15 bad in one window holds; 16 in the next slips on the 16th.
        acquire("tol_acquire");
        for (int k = 0; k < 64; k++)
            blk(1'b1, 1'b1, (k % 4 == 0 && k < 60) ? 2'b11 : 2'b01, 1'b0,
                1'b0, 1'b1, "tol_15_bad");
        for (int k = 0; k < 61; k++)
            blk(1'b1, 1'b1, (k % 4 == 0) ? 2'b00 : 2'b10, 1'b0,
                k == 60, k != 60, "tol_16_bad");
        blk(1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, "tol_post_slip1");
        blk(1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, "tol_post_slip2");

        // Gearbox gaps every 32 cycles with a bad header on the skip cycle.
        do_reset();
        begin
            int nvalid = 0;
            for (int i = 0; nvalid < 64; i++) begin
                if (i % 32 == 31) begin
                    blk(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, "gap_skip");
                end else begin
                    nvalid++;
                    blk(1'b1, 1'b1, 2'b01, 1'b0, 1'b0, nvalid == 64, "gap_valid");
                end
            end
            blk(1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 1'b1, "gap_skip_locked");
        end

        // Reset during SLIP and reset at the triggering edge both discard the slip.
        do_reset();
        blk(1'b1, 1'b1, 2'b11, 1'b0, 1'b1, 1'b0, "rst_slip_enter");
        blk(1'b1, 1'b1, 2'b11, 1'b1, 1'b0, 1'b0, "rst_in_slip");
        blk(1'b1, 1'b1, 2'b11, 1'b0, 1'b1, 1'b0, "rst_unlock_after");
        blk(1'b1, 1'b1, 2'b11, 1'b1, 1'b0, 1'b0, "rst_hides_slip");
        blk(1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, "rst_release");

        // Coincident boundary: 15 bad ending on the 64th holds, 16 bad ending there slips.
        acquire("coin_acquire");
        for (int k = 0; k < 64; k++)
            blk(1'b1, 1'b1, (k >= 49) ? 2'b11 : 2'b01, 1'b0, 1'b0, 1'b1, "coin_15_end");
        for (int k = 0; k < 64; k++)
            blk(1'b1, 1'b1, (k >= 48) ? 2'b00 : 2'b10, 1'b0,
                k == 63, k != 63, "coin_16_end");
        blk(1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, "coin_no_double_slip");

        @(negedge clk);
        @(negedge clk);
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected entries left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
